// File: rtl/edge_tx_pkg.sv
// edge_tx_pkg: shared types and constants for the edge stream transmitter.
//   PACK_FACTOR  - pixels folded into one byte when EDGE_BITPACK_EN is defined
//   cnt_width()  - width of a 0..n-1 counter (never less than 1 bit)
//   tx_entry_t   - default FIFO entry: {data, sof, eol, eof}
package edge_tx_pkg;

    localparam int PACK_FACTOR = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;
    localparam int COL_W_DEF      = cnt_width(IMG_WIDTH_DEF);
    localparam int ROW_W_DEF      = cnt_width(IMG_HEIGHT_DEF);
    localparam int TX_DATA_W      = 8;

    typedef struct packed {
        logic [TX_DATA_W-1:0] data;
        logic                 sof;
        logic                 eol;
        logic                 eof;
    } tx_entry_t;

endpackage

// File: rtl/edge_tx_fifo.sv
// edge_tx_fifo: synchronous FIFO of framed stream entries.
// Ports:
//   clk, rstN         - clock, synchronous active-low reset (flushes pointers)
//   push, wr_entry    - write request and entry; accepted when not full, or
//                       when full and a pop happens on the same edge
//   pop, rd_entry     - read request and head entry (head valid when !empty)
//   full, empty       - occupancy flags
//   level             - current occupancy, 0..DEPTH
module edge_tx_fifo
    import edge_tx_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = tx_entry_t
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   push,
    input  entry_t                 wr_entry,
    input  logic                   pop,
    output entry_t                 rd_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, the write slot is the head slot being popped this edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    assign rd_entry = mem[rd_ptr];
    assign level    = count;

endmodule

// File: rtl/edge_stream_tx.sv
// edge_stream_tx: buffers the free-running hysteresis pixel stream and
// re-emits it on a valid/ready interface with frame markers.
// Ports:
//   clk, rstN                - clock, synchronous active-low reset
//   pixel_in, pixel_in_valid - upstream pixels, no backpressure
//   m_data, m_valid, m_ready - output beat handshake
//   m_sof, m_eol, m_eof      - beat markers (eof beats also carry eol)
//   overflow                 - sticky, a pixel (or packed byte) was dropped
//   frame_done               - one-cycle pulse after the eof beat handshakes
//   fifo_level               - buffer occupancy
// Build option: EDGE_BITPACK_EN packs 8 pixels into one byte
// (bit = pixel != 0, LSB first); m_data is then 8 bits wide.
module edge_stream_tx
    import edge_tx_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 8,
`ifdef EDGE_BITPACK_EN
    localparam int OUT_W = PACK_FACTOR,
`else
    localparam int OUT_W = DATA_WIDTH,
`endif
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_in_valid,
    output logic [OUT_W-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic                  overflow,
    output logic                  frame_done,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    if (IMG_WIDTH < 2) begin : g_bad_width
        $error("edge_stream_tx: IMG_WIDTH must be >= 2");
    end
    if (IMG_HEIGHT < 1) begin : g_bad_height
        $error("edge_stream_tx: IMG_HEIGHT must be >= 1");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("edge_stream_tx: FIFO_DEPTH must be a power of 2 and >= 4");
    end

    // Same layout as tx_entry_t, sized to the beat width of this build.
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } entry_t;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             at_eol;
    logic             at_eof;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    entry_t           wr_entry;
    entry_t           rd_entry;

    assign at_eol = (col == COL_LAST);
    assign at_eof = at_eol && (row == ROW_LAST);

    // Raster position advances on every input pixel, dropped or not.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            col <= '0;
            row <= '0;
        end else if (pixel_in_valid) begin
            if (at_eol) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

`ifdef EDGE_BITPACK_EN
    localparam int SUB_W = $clog2(PACK_FACTOR);

    if (IMG_WIDTH % PACK_FACTOR != 0) begin : g_bad_pack
        $error("edge_stream_tx: IMG_WIDTH must be a multiple of 8 with EDGE_BITPACK_EN");
    end

    logic [PACK_FACTOR-2:0] acc;
    logic                   pix_bit;
    logic                   byte_last;

    assign pix_bit   = |pixel_in;
    assign byte_last = &col[SUB_W-1:0];

    // The last pixel of a byte is not stored; it goes straight into the MSB.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            acc <= '0;
        end else if (pixel_in_valid && !byte_last) begin
            for (int i = 0; i < PACK_FACTOR - 1; i++) begin
                if (col[SUB_W-1:0] == SUB_W'(i)) acc[i] <= pix_bit;
            end
        end
    end

    // Markers are resolved on the byte's last pixel: the byte holding col 0
    // ends at col PACK_FACTOR-1.
    always_comb begin
        push_req      = pixel_in_valid && byte_last;
        wr_entry.data = {pix_bit, acc};
        wr_entry.sof  = (col == COL_W'(PACK_FACTOR - 1)) && (row == '0);
        wr_entry.eol  = at_eol;
        wr_entry.eof  = at_eof;
    end
`else
    always_comb begin
        push_req      = pixel_in_valid;
        wr_entry.data = pixel_in;
        wr_entry.sof  = (col == '0) && (row == '0);
        wr_entry.eol  = at_eol;
        wr_entry.eof  = at_eof;
    end
`endif

    assign pop  = !empty && m_ready;
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    edge_tx_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .rstN     (rstN),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (rd_entry),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            frame_done <= pop && rd_entry.eof;
        end
    end

    // Gate the head so outputs read as zero whenever nothing is buffered.
    assign m_valid = !empty;
    assign m_data  = empty ? '0 : rd_entry.data;
    assign m_sof   = !empty && rd_entry.sof;
    assign m_eol   = !empty && rd_entry.eol;
    assign m_eof   = !empty && rd_entry.eof;

endmodule

// File: tb/tb_edge_stream_tx.sv
module tb_edge_stream_tx;
`ifdef EDGE_BITPACK_EN
    localparam int W = 8;
    localparam int H = 1;
`else
    localparam int W = 4;
    localparam int H = 2;
`endif
    localparam int D = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         r;
        int         lvl;
        bit         ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] pixel_in = '0;
    logic       pixel_in_valid = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid, m_sof, m_eol, m_eof, overflow, frame_done;
    logic [2:0] fifo_level;

    always #5 clk = ~clk;

    edge_stream_tx #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .FIFO_DEPTH (D),
        .DATA_WIDTH (8)
    ) dut (
        .clk            (clk),
        .rstN           (rstN),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_sof          (m_sof),
        .m_eol          (m_eol),
        .m_eof          (m_eof),
        .overflow       (overflow),
        .frame_done     (frame_done),
        .fifo_level     (fifo_level)
    );

    int         checks = 0;
    int         errors = 0;
    beat_t      exp_q[$];
    int         mlevel, mcol, mrow, fd_count;
    bit         movf, mfd;
    logic [7:0] macc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mlevel = 0; mcol = 0; mrow = 0; movf = 0; mfd = 0; macc = '0;
    endtask

    task automatic do_reset(input int n);
        rstN = 1'b0; pixel_in_valid = 1'b0; pixel_in = '0; m_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        model_reset();
        check("rst_m_valid", m_valid, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_m_data", m_data, 0);
        check("rst_markers", {m_sof, m_eol, m_eof}, 0);
        rstN = 1'b1;
    endtask

    // One clock: drive inputs, compare the head beat against the scoreboard,
    // advance the reference model, then check post-edge state.
    task automatic step(input bit v, input logic [7:0] d, input bit r);
        beat_t head, nb;
        bit    pop, req, was_full;
        pixel_in_valid = v; pixel_in = d; m_ready = r;
        #1;
        check("m_valid", m_valid, (mlevel > 0));
        was_full = (mlevel == D);
        pop = (mlevel > 0) && r;
        mfd = 0;
        if (mlevel > 0) begin
            head = exp_q[0];
            check("m_data", m_data, head.data);
            check("markers", {m_sof, m_eol, m_eof}, {head.sof, head.eol, head.eof});
            if (pop) begin
                void'(exp_q.pop_front());
                mfd = head.eof;
                mlevel--;
            end
        end
        req = 0;
        nb = '0;
        if (v) begin
            nb.eol = (mcol == W - 1);
            nb.eof = nb.eol && (mrow == H - 1);
`ifdef EDGE_BITPACK_EN
            macc[mcol % 8] = (d != 0);
            nb.data = macc;
            nb.sof  = (mcol == 7) && (mrow == 0);
            req     = (mcol % 8 == 7);
`else
            nb.data = d;
            nb.sof  = (mcol == 0) && (mrow == 0);
            req     = 1;
`endif
            if (nb.eol) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
        if (req) begin
            if (!was_full || pop) begin
                exp_q.push_back(nb);
                mlevel++;
            end else begin
                movf = 1;
            end
        end
        @(posedge clk);
        #1;
        check("fifo_level", fifo_level, mlevel);
        check("overflow", overflow, movf);
        check("frame_done", frame_done, mfd);
        if (frame_done) fd_count++;
    endtask

    vec_t vecs[11];

    initial begin
        // level / overflow after each cycle of the drop-and-recover sequence
        vecs[0]  = '{1, 8'h20, 0, 1, 0};
        vecs[1]  = '{1, 8'h21, 0, 2, 0};
        vecs[2]  = '{1, 8'h22, 0, 3, 0};
        vecs[3]  = '{1, 8'h23, 0, 4, 0};
        vecs[4]  = '{1, 8'h24, 0, 4, 1};
        vecs[5]  = '{0, 8'h00, 1, 3, 1};
        vecs[6]  = '{0, 8'h00, 1, 2, 1};
        vecs[7]  = '{0, 8'h00, 1, 1, 1};
        vecs[8]  = '{0, 8'h00, 1, 0, 1};
        vecs[9]  = '{1, 8'h25, 1, 1, 1};
        vecs[10] = '{0, 8'h00, 1, 0, 1};

        model_reset();
        do_reset(2);

`ifdef EDGE_BITPACK_EN
        begin
            logic [7:0] pix [8];
            pix[0] = 8'hFF; pix[1] = 8'h00; pix[2] = 8'h00; pix[3] = 8'hFF;
            pix[4] = 8'h00; pix[5] = 8'h00; pix[6] = 8'h00; pix[7] = 8'h01;
            fd_count = 0;
            for (int i = 0; i < 8; i++) step(1, pix[i], 0);
            check("pack_level", fifo_level, 1);
            check("pack_byte", m_data, 8'h89);
            check("pack_markers", {m_sof, m_eol, m_eof}, 3'b111);
            step(0, 8'h00, 1);
            step(0, 8'h00, 1);
            check("pack_frame_done_count", fd_count, 1);
        end
`else
        // back-to-back frame with the sink always ready
        fd_count = 0;
        for (int i = 0; i < 8; i++) step(1, 8'h10 + 8'(i), 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        check("frame_done_count", fd_count, 1);
        check("stream_overflow", overflow, 0);

        // stall, overflow, drain; the dropped pixel still consumes row 1 col 0
        do_reset(2);
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].r);
            check("tbl_level", fifo_level, vecs[i].lvl);
            check("tbl_overflow", overflow, vecs[i].ovf);
            if (i == 9) begin
                check("after_drop_data", m_data, 8'h25);
                check("after_drop_markers", {m_sof, m_eol, m_eof}, 3'b000);
            end
        end
        step(1, 8'h26, 1);
        step(1, 8'h27, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);

        // full FIFO with simultaneous push and pop
        do_reset(2);
        for (int i = 0; i < 4; i++) step(1, 8'h30 + 8'(i), 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 8'h34 + 8'(i), 1);
            check("full_pp_level", fifo_level, 4);
            check("full_pp_overflow", overflow, 0);
        end
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        check("full_pp_drained", fifo_level, 0);

        // reset mid-frame discards buffered data and restarts framing
        do_reset(2);
        for (int i = 0; i < 3; i++) step(1, 8'h40 + 8'(i), 0);
        check("pre_rst_level", fifo_level, 3);
        do_reset(1);
        step(1, 8'h55, 1);
        check("post_rst_data", m_data, 8'h55);
        check("post_rst_sof", m_sof, 1);
        step(0, 8'h00, 1);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
